p405s_spr_dcr_xfer: RTL
=======================

P405S_SPR_DCR_XFER -- requirements
Module: p405s_spr_dcr_xfer

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32: data bus width.
- ADDR_W, default 10: SPR/DCR address width.
- NCH, default 4: SPR destination channels; power of two, 2..16.
- TMO, default 32: DCR acknowledge timeout in cycles; range 2..255.
- CW = log2(NCH).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CB, in, 1: clock; all state updates on its rising edge.
- resetCore_NEG, in, 1: reset; asynchronous, active-low.
- exeSprUnitEn_NEG, in, 1: request strobe, active-low.
- exeSprDataEn_NEG, in, 1: write qualifier, active-low; 0 = write, 1 = read.
- exeDcrOp, in, 1: 1 = DCR operation, 0 = SPR operation.
- aBus, in, [0:DATA_W-1]: write data.
- bBus, in, [0:ADDR_W-1]: address; bBus[0:CW-1] selects the SPR channel.
- sprRdDataBus, in, [0:NCH*DATA_W-1]: per-channel SPR read data; channel k occupies bits [k*DATA_W : k*DATA_W+DATA_W-1].
- dcrAck, in, 1: DCR acknowledge.
- dcrRdData, in, [0:DATA_W-1]: DCR read data.
- EXE_sprAddr, out, [0:ADDR_W-1]: registered SPR address.
- EXE_sprDataBus, out, [0:DATA_W-1]: registered SPR write data.
- EXE_sprWrStb, out, [0:NCH-1]: one-hot SPR write strobe.
- EXE_sprRdStb, out, [0:NCH-1]: one-hot SPR read strobe.
- EXE_dcrReq, out, 1: DCR request.
- EXE_dcrWrite, out, 1: DCR direction; 1 = write.
- EXE_dcrAddr, out, [0:ADDR_W-1]: DCR address.
- EXE_dcrDataBus, out, [0:DATA_W-1]: DCR write data.
- exeSprBusy, out, 1: unit occupied; new requests ignored.
- exeSprDone, out, 1: one-cycle completion pulse.
- exeRdData, out, [0:DATA_W-1]: read return data.
- exeDcrTimeout, out, 1: asserted with exeSprDone when a DCR access timed out.

Function
REQ-003 The FSM SHALL have states IDLE, SPR_ACC, SPR_RET, DCR_WAIT and DONE.
REQ-004 In IDLE, exeSprUnitEn_NEG=0 SHALL capture aBus, bBus, exeDcrOp and the write qualifier into registers at the clock edge (cycle T).
REQ-005 An SPR request SHALL transition IDLE->SPR_ACC; a DCR request SHALL transition IDLE->DCR_WAIT.
REQ-006 In SPR_ACC (cycle T+1) the block SHALL drive the captured address and data, and assert the strobe bit selected by bBus[0:CW-1]: EXE_sprWrStb for a write, EXE_sprRdStb for a read; all other strobe bits SHALL be 0.
REQ-007 An SPR write SHALL pulse exeSprDone in T+1 and go SPR_ACC->IDLE.
REQ-008 An SPR read SHALL sample the selected channel's slice of sprRdDataBus in T+1, present it on exeRdData with exeSprDone in T+2 (state SPR_RET), then return to IDLE.
REQ-009 In DCR_WAIT the block SHALL hold EXE_dcrReq=1 with stable EXE_dcrAddr, EXE_dcrWrite and EXE_dcrDataBus, and SHALL increment an 8-bit wait counter each cycle, starting at 0.
REQ-010 dcrAck=1 in DCR_WAIT SHALL move to DONE on the next edge, drop EXE_dcrReq, and capture dcrRdData on reads (write: exeRdData=0). In DONE, exeSprDone SHALL be 1 for one cycle, then IDLE.
REQ-011 If the wait counter reaches TMO-1 without an acknowledge, the block SHALL move to DONE with exeDcrTimeout=1 and exeRdData=0.
REQ-012 dcrAck and timeout in the same cycle SHALL resolve as an acknowledge; exeDcrTimeout SHALL be 0.
REQ-013 exeSprBusy SHALL be 1 in SPR_RET, DCR_WAIT and DONE, and 0 in IDLE and SPR_ACC.
REQ-014 A request arriving in SPR_ACC SHALL be accepted as in IDLE (back-to-back SPR throughput of one per cycle); requests in any busy state SHALL be ignored.
REQ-015 dcrAck outside DCR_WAIT SHALL be ignored.
REQ-016 When no strobe or request is active, EXE_sprDataBus, EXE_dcrDataBus and exeRdData SHALL be 0.

Reset
REQ-017 resetCore_NEG=0 SHALL immediately force IDLE and clear the counter and all outputs to 0, including during a pending DCR access; no exeSprDone SHALL follow reset.

Verification
REQ-018 SPR write, NCH=4, bBus=10'b01_0000_0011, aBus=32'hDEADBEEF at T -> T+1: EXE_sprWrStb=4'b0100, EXE_sprDataBus=32'hDEADBEEF, exeSprDone=1; T+2: all 0.
REQ-019 SPR read of channel 3, with channel 3 slice=32'h12345678 -> T+1: EXE_sprRdStb=4'b0001; T+2: exeRdData=32'h12345678, exeSprDone=1, exeSprBusy=1.
REQ-020 DCR read, dcrAck asserted 5 cycles after T, dcrRdData=32'hA5A5A5A5 -> EXE_dcrReq high for 5 cycles; next cycle exeSprDone=1, exeRdData=32'hA5A5A5A5, exeDcrTimeout=0.
REQ-021 DCR write, no acknowledge, TMO=32 -> EXE_dcrReq held 32 cycles; then exeSprDone=1, exeDcrTimeout=1, exeRdData=0; a second request issued while busy is ignored.
REQ-022 dcrAck in the same cycle the counter reaches TMO-1 -> exeSprDone=1, exeDcrTimeout=0.
REQ-023 resetCore_NEG pulled low 3 cycles into DCR_WAIT -> EXE_dcrReq=0 and exeSprBusy=0 asynchronously; no exeSprDone after release.

Source files
------------

// File: rtl/p405s_spr_dcr_xfer.sv
// SPR/DCR transfer unit: decodes execute-stage SPR/DCR requests into one-hot SPR
// strobes or a DCR handshake with acknowledge timeout, and returns read data.
module p405s_spr_dcr_xfer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NCH    = 4,
  parameter int TMO    = 32
) (
  input  logic                  CB,
  input  logic                  resetCore_NEG,
  input  logic                  exeSprUnitEn_NEG,
  input  logic                  exeSprDataEn_NEG,
  input  logic                  exeDcrOp,
  input  logic [0:DATA_W-1]     aBus,
  input  logic [0:ADDR_W-1]     bBus,
  input  logic [0:NCH*DATA_W-1] sprRdDataBus,
  input  logic                  dcrAck,
  input  logic [0:DATA_W-1]     dcrRdData,
  output logic [0:ADDR_W-1]     EXE_sprAddr,
  output logic [0:DATA_W-1]     EXE_sprDataBus,
  output logic [0:NCH-1]        EXE_sprWrStb,
  output logic [0:NCH-1]        EXE_sprRdStb,
  output logic                  EXE_dcrReq,
  output logic                  EXE_dcrWrite,
  output logic [0:ADDR_W-1]     EXE_dcrAddr,
  output logic [0:DATA_W-1]     EXE_dcrDataBus,
  output logic                  exeSprBusy,
  output logic                  exeSprDone,
  output logic [0:DATA_W-1]     exeRdData,
  output logic                  exeDcrTimeout
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPR_ACC  = 3'd1,
    SPR_RET  = 3'd2,
    DCR_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [0:ADDR_W-1]   r_addr;
  logic [0:DATA_W-1]   r_wdata;
  logic                r_wr;
  logic                r_dcr;
  logic                r_pend;
  logic [7:0]          r_cnt;
  logic [0:DATA_W-1]   r_rdata;
  logic                r_tmo;

  logic                w_accept;
  logic                w_tmo_hit;
  logic [0:NCH-1]      w_sel;
  logic [0:DATA_W-1]   w_ch_data [NCH];
  logic [0:DATA_W-1]   w_rd_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_sel[gi]     = (r_addr[0:CW-1] == CW'(gi));
      assign w_ch_data[gi] = sprRdDataBus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_rd_sel  = w_ch_data[r_addr[0:CW-1]];
  assign w_accept  = !exeSprUnitEn_NEG && (r_state == IDLE || r_state == SPR_ACC);
  assign w_tmo_hit = (r_cnt == 8'(TMO - 1));

  always_ff @(posedge CB or negedge resetCore_NEG) begin
    if (!resetCore_NEG) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_dcr   <= 1'b0;
      r_pend  <= 1'b0;
      r_cnt   <= 8'd0;
      r_rdata <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr  <= bBus;
        r_wdata <= aBus;
        r_dcr   <= exeDcrOp;
        r_wr    <= !exeSprDataEn_NEG;
      end
      // A request taken while an SPR read is in SPR_ACC is held until SPR_RET ends.
      r_pend <= (r_state == SPR_ACC) && !r_wr && w_accept;
      if (w_accept)
        r_cnt <= 8'd0;
      else if (r_state == DCR_WAIT)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == SPR_ACC && !r_wr) begin
        r_rdata <= w_rd_sel;
      end else if (r_state == DCR_WAIT && dcrAck) begin
        r_rdata <= r_wr ? '0 : dcrRdData;
        r_tmo   <= 1'b0;
      end else if (r_state == DCR_WAIT && w_tmo_hit) begin
        r_rdata <= '0;
        r_tmo   <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:
        if (w_accept) w_state_next = exeDcrOp ? DCR_WAIT : SPR_ACC;
      SPR_ACC:
        if (!r_wr)         w_state_next = SPR_RET;
        else if (w_accept) w_state_next = exeDcrOp ? DCR_WAIT : SPR_ACC;
        else               w_state_next = IDLE;
      SPR_RET:
        if (r_pend) w_state_next = r_dcr ? DCR_WAIT : SPR_ACC;
        else        w_state_next = IDLE;
      DCR_WAIT:
        if (dcrAck || w_tmo_hit) w_state_next = DONE;
      DONE:
        w_state_next = IDLE;
      default:
        w_state_next = IDLE;
    endcase
  end

  always_comb begin
    EXE_sprAddr    = '0;
    EXE_sprDataBus = '0;
    EXE_sprWrStb   = '0;
    EXE_sprRdStb   = '0;
    EXE_dcrReq     = 1'b0;
    EXE_dcrWrite   = 1'b0;
    EXE_dcrAddr    = '0;
    EXE_dcrDataBus = '0;
    exeSprBusy     = 1'b0;
    exeSprDone     = 1'b0;
    exeRdData      = '0;
    exeDcrTimeout  = 1'b0;
    case (r_state)
      SPR_ACC: begin
        EXE_sprAddr    = r_addr;
        EXE_sprDataBus = r_wdata;
        if (r_wr) begin
          EXE_sprWrStb = w_sel;
          exeSprDone   = 1'b1;
        end else begin
          EXE_sprRdStb = w_sel;
        end
      end
      SPR_RET: begin
        exeSprBusy = 1'b1;
        exeSprDone = 1'b1;
        exeRdData  = r_rdata;
      end
      DCR_WAIT: begin
        exeSprBusy     = 1'b1;
        EXE_dcrReq     = 1'b1;
        EXE_dcrWrite   = r_wr;
        EXE_dcrAddr    = r_addr;
        EXE_dcrDataBus = r_wdata;
      end
      DONE: begin
        exeSprBusy    = 1'b1;
        exeSprDone    = 1'b1;
        exeRdData     = r_rdata;
        exeDcrTimeout = r_tmo;
      end
      default: ;
    endcase
  end

endmodule
